// File: rtl/cnn_pkg.sv
// Shared defaults, derived sizes and FSM encoding for the CNN window generator.
package cnn_pkg;

    localparam int unsigned KX_DEF     = 5;
    localparam int unsigned KY_DEF     = 5;
    localparam int unsigned I_F_BW_DEF = 8;
    localparam int unsigned IMG_W_DEF  = 28;
    localparam int unsigned IMG_H_DEF  = 28;

    localparam int unsigned ROW_W = $clog2(IMG_H_DEF);
    localparam int unsigned COL_W = $clog2(IMG_W_DEF);
    localparam int unsigned OUT_W = IMG_W_DEF - KX_DEF + 1;
    localparam int unsigned OUT_H = IMG_H_DEF - KY_DEF + 1;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/cnn_line_buffer.sv
// Single-line delay: data_o is the sample written DEPTH enables ago.
module cnn_line_buffer
    import cnn_pkg::*;
#(
    parameter int unsigned DEPTH = IMG_W_DEF,
    parameter int unsigned WIDTH = I_F_BW_DEF
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    // Contents are don't-care after reset, so the delay line carries no reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Shift the whole line by one position per accepted pixel.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= data_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign data_o = mem_q[DEPTH-1];

endmodule

// File: rtl/cnn_window_gen.sv
// Streaming KY x KX sliding-window generator (valid convolution, stride 1).
module cnn_window_gen
    import cnn_pkg::*;
#(
    parameter int unsigned KX     = KX_DEF,
    parameter int unsigned KY     = KY_DEF,
    parameter int unsigned I_F_BW = I_F_BW_DEF,
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_in_valid,
    input  logic [I_F_BW-1:0]          i_in_pixel,
    output logic                       o_ot_valid,
    output logic [KX*KY*I_F_BW-1:0]    o_ot_fmap,
    output logic [$clog2(IMG_H)-1:0]   o_ot_row,
    output logic [$clog2(IMG_W)-1:0]   o_ot_col,
    output logic                       o_frame_done
);

    localparam int unsigned ROW_BW = $clog2(IMG_H);
    localparam int unsigned COL_BW = $clog2(IMG_W);
    localparam int unsigned FMAP_W = KX * KY * I_F_BW;

    localparam logic [ROW_BW-1:0] ROW_LAST = ROW_BW'(IMG_H - 1);
    localparam logic [ROW_BW-1:0] ROW_WIN0 = ROW_BW'(KY - 1);
    localparam logic [COL_BW-1:0] COL_LAST = COL_BW'(IMG_W - 1);
    localparam logic [COL_BW-1:0] COL_WIN0 = COL_BW'(KX - 1);

    // lb_tap[0] is one line above the incoming pixel, lb_tap[KY-2] the oldest line.
    logic [I_F_BW-1:0] lb_tap [KY-1];

    for (genvar g = 0; g < int'(KY) - 1; g++) begin : g_lb
        if (g == 0) begin : g_first
            cnn_line_buffer #(.DEPTH(IMG_W), .WIDTH(I_F_BW)) u_lb (
                .clk    (clk),
                .en_i   (i_in_valid),
                .data_i (i_in_pixel),
                .data_o (lb_tap[g])
            );
        end else begin : g_next
            cnn_line_buffer #(.DEPTH(IMG_W), .WIDTH(I_F_BW)) u_lb (
                .clk    (clk),
                .en_i   (i_in_valid),
                .data_i (lb_tap[g-1]),
                .data_o (lb_tap[g])
            );
        end
    end

    logic [I_F_BW-1:0] win_q [KY][KX];
    logic [I_F_BW-1:0] win_d [KY][KX];
    logic [FMAP_W-1:0] win_flat;

    state_e            state_q, state_d;
    logic [ROW_BW-1:0] row_q, row_d;
    logic [COL_BW-1:0] col_q, col_d;
    logic              win_ok, frame_end;

    logic              valid_q, done_q;
    logic [FMAP_W-1:0] fmap_q;
    logic [ROW_BW-1:0] orow_q;
    logic [COL_BW-1:0] ocol_q;

    // Window shifted left by one with the new column entering on the right.
    always_comb begin
        win_d    = win_q;
        win_flat = '0;
        for (int k = 0; k < int'(KY); k++) begin
            for (int j = 0; j < int'(KX) - 1; j++) begin
                win_d[k][j] = win_q[k][j+1];
            end
        end
        for (int k = 0; k < int'(KY) - 1; k++) begin
            win_d[k][KX-1] = lb_tap[int'(KY) - 2 - k];
        end
        win_d[KY-1][KX-1] = i_in_pixel;
        for (int k = 0; k < int'(KY); k++) begin
            for (int j = 0; j < int'(KX); j++) begin
                win_flat[(k*int'(KX)+j)*int'(I_F_BW) +: I_F_BW] = win_d[k][j];
            end
        end
    end

    // Raster counters, frame-phase FSM and output gating.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        frame_end = i_in_valid && (col_q == COL_LAST) && (row_q == ROW_LAST);
        // Counter gate alone excludes fill rows and stale columns of the previous row.
        win_ok    = i_in_valid && (row_q >= ROW_WIN0) && (col_q >= COL_WIN0);
        if (i_in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_BW'(1);
                unique case (state_q)
                    S_FILL: if (row_q == ROW_WIN0 && row_q != ROW_LAST) state_d = S_RUN;
                    S_RUN:  if (row_q == ROW_LAST) state_d = S_FILL;
                    default: state_d = S_FILL;
                endcase
            end else begin
                col_d = col_q + COL_BW'(1);
            end
        end
    end

    // State and registered outputs; window fields hold while no window is emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            row_q   <= '0;
            col_q   <= '0;
            win_q   <= '{default: '0};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            fmap_q  <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
        end else begin
            valid_q <= win_ok;
            done_q  <= frame_end;
            if (i_in_valid) begin
                state_q <= state_d;
                row_q   <= row_d;
                col_q   <= col_d;
                win_q   <= win_d;
            end
            if (win_ok) begin
                fmap_q <= win_flat;
                orow_q <= row_q - ROW_WIN0;
                ocol_q <= col_q - COL_WIN0;
            end
        end
    end

    assign o_ot_valid   = valid_q;
    assign o_ot_fmap    = fmap_q;
    assign o_ot_row     = orow_q;
    assign o_ot_col     = ocol_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen at default 28x28 map, 5x5 window.
module tb_cnn_window_gen;

    localparam int KX = 5;
    localparam int KY = 5;
    localparam int BW = 8;
    localparam int W  = 28;
    localparam int H  = 28;
    localparam int FW = KX * KY * BW;

    logic              clk;
    logic              reset;
    logic              i_in_valid;
    logic [BW-1:0]     i_in_pixel;
    logic              o_ot_valid;
    logic [FW-1:0]     o_ot_fmap;
    logic [4:0]        o_ot_row;
    logic [4:0]        o_ot_col;
    logic              o_frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulses = 0;
    int n_done   = 0;
    int m_r      = 0;
    int m_c      = 0;

    cnn_window_gen #(
        .KX     (KX),
        .KY     (KY),
        .I_F_BW (BW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_in_valid   (i_in_valid),
        .i_in_pixel   (i_in_pixel),
        .o_ot_valid   (o_ot_valid),
        .o_ot_fmap    (o_ot_fmap),
        .o_ot_row     (o_ot_row),
        .o_ot_col     (o_ot_col),
        .o_frame_done (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] pix(input int r, input int c);
        return BW'((r * W + c) % 256);
    endfunction

    function automatic logic [FW-1:0] exp_win(input int orow, input int ocol);
        logic [FW-1:0] v;
        v = '0;
        for (int k = 0; k < KY; k++) begin
            for (int j = 0; j < KX; j++) begin
                v[(k*KX+j)*BW +: BW] = pix(orow + k, ocol + j);
            end
        end
        return v;
    endfunction

    function automatic logic [BW-1:0] el(input logic [FW-1:0] f, input int k, input int j);
        return f[(k*KX+j)*BW +: BW];
    endfunction

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_px(input int r, input int c, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
                i_in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        i_in_valid = 1'b1;
        i_in_pixel = pix(r, c);
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, FW'(o_ot_valid), FW'(0));
        check({tag, "_fmap"},  o_ot_fmap,         FW'(0));
        check({tag, "_row"},   FW'(o_ot_row),     FW'(0));
        check({tag, "_col"},   FW'(o_ot_col),     FW'(0));
        check({tag, "_done"},  FW'(o_frame_done), FW'(0));
    endtask

    initial begin
        int base;
        int acc;
        int first;

        // Output monitor: every window must follow raster output order.
        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    m_r = 0;
                    m_c = 0;
                end else begin
                    if (o_ot_valid) begin
                        check("mon_row",  FW'(o_ot_row), FW'(m_r));
                        check("mon_col",  FW'(o_ot_col), FW'(m_c));
                        check("mon_fmap", o_ot_fmap,     exp_win(m_r, m_c));
                        n_pulses++;
                        if (m_c == W - KX) begin
                            m_c = 0;
                            m_r = (m_r == H - KY) ? 0 : m_r + 1;
                        end else begin
                            m_c++;
                        end
                    end
                    if (o_frame_done) begin
                        n_done++;
                        check("done_valid", FW'(o_ot_valid), FW'(1));
                        check("done_row",   FW'(o_ot_row),   FW'(H - KY));
                        check("done_col",   FW'(o_ot_col),   FW'(W - KX));
                    end
                end
            end
        join_none

        reset      = 1'b1;
        i_in_valid = 1'b0;
        i_in_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst_held");
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_idle_outputs("rst_idle");

        // Two back-to-back frames, continuous valid, directed points.
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    send_px(r, c, 1'b0);
                    if (r == 0 && c == 0) begin
                        check("first_px_valid", FW'(o_ot_valid),   FW'(0));
                        check("first_px_done",  FW'(o_frame_done), FW'(0));
                    end
                    if (r == 4 && c == 4) begin
                        check("w00_valid", FW'(o_ot_valid), FW'(1));
                        check("w00_e00",   FW'(el(o_ot_fmap, 0, 0)), FW'(0));
                        check("w00_e44",   FW'(el(o_ot_fmap, 4, 4)), FW'(116));
                        check("w00_row",   FW'(o_ot_row), FW'(0));
                        check("w00_col",   FW'(o_ot_col), FW'(0));
                    end
                    if (r == 4 && c == 27) begin
                        check("w023_row", FW'(o_ot_row), FW'(0));
                        check("w023_col", FW'(o_ot_col), FW'(23));
                        check("w023_e00", FW'(el(o_ot_fmap, 0, 0)), FW'(23));
                    end
                    if (r == 5 && c < 4) begin
                        check("wrap_novalid", FW'(o_ot_valid), FW'(0));
                        check("wrap_hold_col", FW'(o_ot_col), FW'(23));
                    end
                    if (r == 5 && c == 4) begin
                        check("w10_valid", FW'(o_ot_valid), FW'(1));
                        check("w10_row",   FW'(o_ot_row), FW'(1));
                        check("w10_col",   FW'(o_ot_col), FW'(0));
                        check("w10_e00",   FW'(el(o_ot_fmap, 0, 0)), FW'(28));
                        check("w10_e44",   FW'(el(o_ot_fmap, 4, 4)), FW'(144));
                    end
                    if (r == H - 1 && c == W - 1) begin
                        check("last_done",  FW'(o_frame_done), FW'(1));
                        check("last_valid", FW'(o_ot_valid),   FW'(1));
                    end
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("b2b_pulses", FW'(n_pulses), FW'(2 * 576));
        check("b2b_done",   FW'(n_done),   FW'(2));

        // Random gaps must give the same window sequence and count.
        base = n_pulses;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_px(r, c, 1'b1);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("gap_pulses", FW'(n_pulses - base), FW'(576));
        check("gap_done",   FW'(n_done),          FW'(3));

        // Reset after 300 accepted pixels cancels the in-flight window.
        for (int i = 0; i < 300; i++) begin
            send_px(i / W, i % W, 1'b0);
        end
        check("pre_rst_valid", FW'(o_ot_valid), FW'(1));
        reset      = 1'b1;
        i_in_valid = 1'b1;
        i_in_pixel = 8'hAA;
        @(posedge clk);
        #1;
        check_idle_outputs("mid_rst");
        reset      = 1'b0;
        i_in_valid = 1'b0;
        @(posedge clk);
        #1;
        base  = n_pulses;
        acc   = 0;
        first = 0;
        for (int i = 0; i < H * W; i++) begin
            send_px(i / W, i % W, 1'b0);
            acc++;
            if (o_ot_valid && first == 0) first = acc;
        end
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_first", FW'(first),            FW'(117));
        check("post_rst_pulses", FW'(n_pulses - base), FW'(576));
        check("post_rst_done",   FW'(n_done),          FW'(4));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
